// File: rtl/ppe_rr_sched_w1024_pkg.sv
// Shared constants and pointer-mode encodings for the 1024-wide round-robin scheduler.
package ppe_pkg;

    localparam int unsigned PPE_W    = 1024;
    localparam int unsigned PPE_IDXW = 10;

    typedef enum logic [0:0] {
        PTR_RR     = 1'b0,
        PTR_STICKY = 1'b1
    } ptr_mode_e;

    // Mask of every one-hot position whose binary index has bit_pos set.
    function automatic logic [PPE_W-1:0] idx_bit_mask(input int unsigned bit_pos);
        logic [PPE_W-1:0] m;
        m = {PPE_W{1'b0}};
        for (int i = 0; i < PPE_W; i++) begin
            m[i] = i[bit_pos];
        end
        return m;
    endfunction

endpackage

// File: rtl/ppe_rr_sched_w1024_if.sv
// Request/grant bundle between the requesters, the scheduler and the downstream consumer.
interface ppe_rr_sched_w1024_if;
    import ppe_pkg::*;

    logic [PPE_W-1:0]    req;
    logic                gnt_ready;
    logic                gnt_valid;
    logic [PPE_W-1:0]    gnt_onehot;
    logic [PPE_IDXW-1:0] gnt_idx;
    logic [PPE_IDXW-1:0] ptr;

    modport master (
        output req, gnt_ready,
        input  gnt_valid, gnt_onehot, gnt_idx, ptr
    );

    modport slave (
        input  req, gnt_ready,
        output gnt_valid, gnt_onehot, gnt_idx, ptr
    );
endinterface

// File: rtl/ppe_rr_sched_w1024_onehot2bin.sv
// One-hot to binary converter: each index bit is an OR over the positions carrying that bit.
module onehot2bin_w1024
    import ppe_pkg::*;
(
    input  logic [PPE_W-1:0]    onehot,
    output logic [PPE_IDXW-1:0] idx
);

    for (genvar b = 0; b < PPE_IDXW; b++) begin : g_bit
        localparam logic [PPE_W-1:0] BIT_MASK = idx_bit_mask(b);
        assign idx[b] = |(onehot & BIT_MASK);
    end

endmodule

// File: rtl/ppe_rr_sched_w1024_ppe.sv
// Programmable priority encoder: lowest request at or above P_enc, else lowest overall.
module ppe_w1024
    import ppe_pkg::*;
(
    input  logic [PPE_W-1:0]    Req,
    input  logic [PPE_IDXW-1:0] P_enc,
    output logic [PPE_W-1:0]    Gnt
);

    logic [PPE_W-1:0] hi_s;

    // x & -x isolates the lowest set bit; the upper half is searched first.
    always_comb begin
        hi_s = Req & ({PPE_W{1'b1}} << P_enc);
        if (|hi_s) begin
            Gnt = hi_s & (-hi_s);
        end else begin
            Gnt = Req & (-Req);
        end
    end

endmodule

// File: rtl/ppe_rr_sched_w1024.sv
// Registered round-robin scheduler: one grant per cycle over valid/ready, pointer advanced on accept.
module ppe_rr_sched_w1024
    import ppe_pkg::*;
#(
    parameter logic [PPE_IDXW-1:0] PTR_INIT = 10'd0,
    parameter ptr_mode_e           PTR_MODE = PTR_RR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ppe_rr_sched_w1024_if.slave    bus
);

    logic                gnt_valid_r;
    logic [PPE_W-1:0]    gnt_onehot_r;
    logic [PPE_IDXW-1:0] gnt_idx_r;
    logic [PPE_IDXW-1:0] ptr_r;

    logic [PPE_W-1:0]    req_eff_s;
    logic [PPE_W-1:0]    enc_gnt_s;
    logic [PPE_IDXW-1:0] enc_idx_s;
    logic                any_req_s;
    logic                load_s;
    logic                accept_s;
    logic [PPE_IDXW-1:0] ptr_next_s;

    ppe_w1024 u_ppe (
        .Req   (req_eff_s),
        .P_enc (ptr_r),
        .Gnt   (enc_gnt_s)
    );

    onehot2bin_w1024 u_o2b (
        .onehot (enc_gnt_s),
        .idx    (enc_idx_s)
    );

    // Masking the outstanding winner keeps it from being re-granted while it is accepted.
    always_comb begin
        req_eff_s = bus.req & ~(gnt_onehot_r & {PPE_W{gnt_valid_r}});
        any_req_s = |req_eff_s;
        load_s    = ~gnt_valid_r | bus.gnt_ready;
        accept_s  = gnt_valid_r & bus.gnt_ready;
        case (PTR_MODE)
            PTR_STICKY: ptr_next_s = gnt_idx_r;
            default:    ptr_next_s = gnt_idx_r + 10'd1;
        endcase
    end

    // Grant slot and priority pointer; gnt_idx keeps its last value on an empty load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_valid_r  <= 1'b0;
            gnt_onehot_r <= {PPE_W{1'b0}};
            gnt_idx_r    <= 10'd0;
            ptr_r        <= PTR_INIT;
        end else begin
            if (load_s) begin
                gnt_valid_r  <= any_req_s;
                gnt_onehot_r <= enc_gnt_s;
                if (any_req_s) begin
                    gnt_idx_r <= enc_idx_s;
                end
            end
            if (accept_s) begin
                ptr_r <= ptr_next_s;
            end
        end
    end

    assign bus.gnt_valid  = gnt_valid_r;
    assign bus.gnt_onehot = gnt_onehot_r;
    assign bus.gnt_idx    = gnt_idx_r;
    assign bus.ptr        = ptr_r;

endmodule

// File: tb/tb_ppe_rr_sched_w1024.sv
// Bench for ppe_rr_sched_w1024: directed scoreboard scenarios plus a random run against a reference model.
module tb_ppe_rr_sched_w1024;
    import ppe_pkg::*;

    typedef struct {
        int idx;
        int ptr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    ppe_rr_sched_w1024_if bus0 ();
    ppe_rr_sched_w1024_if bus1 ();

    ppe_rr_sched_w1024 #(.PTR_INIT(10'd0), .PTR_MODE(PTR_RR)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    ppe_rr_sched_w1024 #(.PTR_INIT(10'd0), .PTR_MODE(PTR_STICKY)) dut_sticky (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.req = '0; bus0.gnt_ready = 1'b0;
        bus1.req = '0; bus1.gnt_ready = 1'b0;
        #2;
        checks++;
        if ({bus0.gnt_valid, bus0.gnt_idx, bus0.ptr, bus1.gnt_valid, bus1.gnt_idx, bus1.ptr} !== 22'd0
            || bus0.gnt_onehot !== '0 || bus1.gnt_onehot !== '0) begin
            errors++;
            $display("FAIL reset_values: got v0=%b idx0=%0d ptr0=%0d v1=%b idx1=%0d ptr1=%0d, want all 0",
                     bus0.gnt_valid, bus0.gnt_idx, bus0.ptr, bus1.gnt_valid, bus1.gnt_idx, bus1.ptr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus0.gnt_ready = 1'b1;
        bus1.gnt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus0.gnt_valid !== 1'b0 || bus0.ptr !== 10'd0 || bus1.gnt_valid !== 1'b0 || bus1.ptr !== 10'd0) begin
                errors++;
                $display("FAIL idle_no_req cycle %0d: got v0=%b ptr0=%0d v1=%b ptr1=%0d, want v=0 ptr=0",
                         i, bus0.gnt_valid, bus0.ptr, bus1.gnt_valid, bus1.ptr);
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic [PPE_W-1:0] oh;
        exp_q.push_back('{3, 0});
        exp_q.push_back('{7, 4});
        exp_q.push_back('{900, 8});
        exp_q.push_back('{3, 901});
        exp_q.push_back('{7, 4});
        bus0.req = '0;
        bus0.req[3] = 1'b1; bus0.req[7] = 1'b1; bus0.req[900] = 1'b1;
        bus0.gnt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            oh = '0; oh[e.idx] = 1'b1;
            checks++;
            if (bus0.gnt_valid !== 1'b1 || bus0.gnt_idx !== 10'(e.idx) || bus0.ptr !== 10'(e.ptr) || bus0.gnt_onehot !== oh) begin
                errors++;
                $display("FAIL rr_grant %0d: got v=%b idx=%0d ptr=%0d ones=%0d, want v=1 idx=%0d ptr=%0d ones=1",
                         i, bus0.gnt_valid, bus0.gnt_idx, bus0.ptr, $countones(bus0.gnt_onehot), e.idx, e.ptr);
            end
        end
        bus0.req = '0;
        @(negedge clk);
        checks++;
        if (bus0.gnt_valid !== 1'b0 || bus0.ptr !== 10'd8 || bus0.gnt_onehot !== '0) begin
            errors++;
            $display("FAIL rr_drain: got v=%b ptr=%0d, want v=0 ptr=8", bus0.gnt_valid, bus0.ptr);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [PPE_W-1:0] oh;
        exp_q.push_back('{1022, 8});
        exp_q.push_back('{1023, 1023});
        exp_q.push_back('{0, 0});
        bus0.req = '0;
        bus0.req[1022] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            oh = '0; oh[e.idx] = 1'b1;
            checks++;
            if (bus0.gnt_valid !== 1'b1 || bus0.gnt_idx !== 10'(e.idx) || bus0.ptr !== 10'(e.ptr) || bus0.gnt_onehot !== oh) begin
                errors++;
                $display("FAIL wrap_grant %0d: got v=%b idx=%0d ptr=%0d, want v=1 idx=%0d ptr=%0d",
                         i, bus0.gnt_valid, bus0.gnt_idx, bus0.ptr, e.idx, e.ptr);
            end
            if (i == 0) begin
                bus0.req = '0;
                bus0.req[0] = 1'b1; bus0.req[1023] = 1'b1;
            end else if (i == 2) begin
                bus0.req = '0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus0.gnt_valid !== 1'b0 || bus0.ptr !== 10'd1 || bus0.gnt_idx !== 10'd0) begin
            errors++;
            $display("FAIL wrap_drain: got v=%b idx=%0d ptr=%0d, want v=0 idx=0 ptr=1",
                     bus0.gnt_valid, bus0.gnt_idx, bus0.ptr);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        exp_q.push_back('{5, 1});
        bus0.req = '0;
        bus0.req[5] = 1'b1;
        bus0.gnt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = exp_q[0];
            checks++;
            if (bus0.gnt_valid !== 1'b1 || bus0.gnt_idx !== 10'(e.idx) || bus0.ptr !== 10'(e.ptr)
                || bus0.gnt_onehot[5] !== 1'b1 || $countones(bus0.gnt_onehot) != 1) begin
                errors++;
                $display("FAIL stall_hold %0d: got v=%b idx=%0d ptr=%0d ones=%0d, want v=1 idx=%0d ptr=%0d",
                         i, bus0.gnt_valid, bus0.gnt_idx, bus0.ptr, $countones(bus0.gnt_onehot), e.idx, e.ptr);
            end
            if (i == 1) bus0.req = '0;
        end
        bus0.gnt_ready = 1'b1;
        void'(exp_q.pop_front());
        @(negedge clk);
        checks++;
        if (bus0.gnt_valid !== 1'b0 || bus0.ptr !== 10'd6 || bus0.gnt_onehot !== '0 || bus0.gnt_idx !== 10'd5) begin
            errors++;
            $display("FAIL stall_accept: got v=%b idx=%0d ptr=%0d, want v=0 idx=5 ptr=6",
                     bus0.gnt_valid, bus0.gnt_idx, bus0.ptr);
        end
    endtask

    task automatic test_sticky();
        exp_t e;
        logic [PPE_W-1:0] oh;
        exp_q.push_back('{10, 0});
        exp_q.push_back('{20, 10});
        exp_q.push_back('{10, 20});
        bus1.req = '0;
        bus1.req[10] = 1'b1; bus1.req[20] = 1'b1;
        bus1.gnt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            oh = '0; oh[e.idx] = 1'b1;
            checks++;
            if (bus1.gnt_valid !== 1'b1 || bus1.gnt_idx !== 10'(e.idx) || bus1.ptr !== 10'(e.ptr) || bus1.gnt_onehot !== oh) begin
                errors++;
                $display("FAIL sticky_grant %0d: got v=%b idx=%0d ptr=%0d, want v=1 idx=%0d ptr=%0d",
                         i, bus1.gnt_valid, bus1.gnt_idx, bus1.ptr, e.idx, e.ptr);
            end
        end
        bus1.req = '0;
        @(negedge clk);
        checks++;
        if (bus1.gnt_valid !== 1'b0 || bus1.ptr !== 10'd10) begin
            errors++;
            $display("FAIL sticky_drain: got v=%b ptr=%0d, want v=0 ptr=10", bus1.gnt_valid, bus1.ptr);
        end
    endtask

    // Circular search from p: the first requester at or after p wins.
    function automatic int find_grant(input logic [PPE_W-1:0] eff, input int p);
        for (int k = 0; k < PPE_W; k++) begin
            if (eff[(p + k) % PPE_W]) return (p + k) % PPE_W;
        end
        return -1;
    endfunction

    task automatic test_random();
        logic             m_valid [2];
        int               m_idx   [2];
        int               m_ptr   [2];
        logic             o_valid [2];
        logic [PPE_W-1:0] o_oh    [2];
        int               o_idx   [2];
        int               o_ptr   [2];
        logic [PPE_W-1:0] r, eff, oh;
        logic             rdy, acc, did_rst;
        int               g, nptr, n;
        r = '0; rdy = 1'b0; did_rst = 1'b0;
        bus0.req = '0; bus1.req = '0; bus0.gnt_ready = 1'b0; bus1.gnt_ready = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int m = 0; m < 2; m++) begin m_valid[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 0; end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = '0;
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) r[$urandom_range(0, PPE_W - 1)] = 1'b1;
            end
            rdy = ($urandom_range(0, 3) != 0);
            bus0.req = r; bus1.req = r; bus0.gnt_ready = rdy; bus1.gnt_ready = rdy;
            for (int m = 0; m < 2; m++) begin
                oh = '0;
                if (m_valid[m]) oh[m_idx[m]] = 1'b1;
                eff  = r & ~oh;
                acc  = m_valid[m] & rdy;
                nptr = acc ? ((m == 1) ? m_idx[m] : (m_idx[m] + 1) % PPE_W) : m_ptr[m];
                if (!m_valid[m] || rdy) begin
                    g = find_grant(eff, m_ptr[m]);
                    m_valid[m] = (g >= 0);
                    if (g >= 0) m_idx[m] = g;
                end
                m_ptr[m] = nptr;
            end
            @(negedge clk);
            o_valid[0] = bus0.gnt_valid; o_oh[0] = bus0.gnt_onehot; o_idx[0] = int'(bus0.gnt_idx); o_ptr[0] = int'(bus0.ptr);
            o_valid[1] = bus1.gnt_valid; o_oh[1] = bus1.gnt_onehot; o_idx[1] = int'(bus1.gnt_idx); o_ptr[1] = int'(bus1.ptr);
            for (int m = 0; m < 2; m++) begin
                oh = '0;
                if (m_valid[m]) oh[m_idx[m]] = 1'b1;
                checks++;
                if (o_valid[m] !== m_valid[m] || o_idx[m] != m_idx[m] || o_ptr[m] != m_ptr[m]
                    || o_oh[m] !== oh || $countones(o_oh[m]) > 1) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL random dut%0d cyc %0d: got v=%b idx=%0d ptr=%0d ones=%0d, want v=%b idx=%0d ptr=%0d",
                                 m, cyc, o_valid[m], o_idx[m], o_ptr[m], $countones(o_oh[m]), m_valid[m], m_idx[m], m_ptr[m]);
                end
            end
            if (!did_rst && cyc >= 4000 && m_valid[0] && !rdy) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if ({bus0.gnt_valid, bus0.gnt_idx, bus0.ptr, bus1.gnt_valid, bus1.gnt_idx, bus1.ptr} !== 22'd0
                    || bus0.gnt_onehot !== '0 || bus1.gnt_onehot !== '0) begin
                    errors++;
                    $display("FAIL mid_stall_reset: got v0=%b idx0=%0d ptr0=%0d v1=%b ptr1=%0d, want all 0",
                             bus0.gnt_valid, bus0.gnt_idx, bus0.ptr, bus1.gnt_valid, bus1.ptr);
                end
                @(negedge clk);
                rst_n = 1'b1;
                did_rst = 1'b1;
                for (int m = 0; m < 2; m++) begin m_valid[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 0; end
            end
        end
        checks++;
        if (!did_rst) begin
            errors++;
            $display("FAIL mid_stall_reset_reached: got 0, want 1");
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_sticky();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
